rv32_bus_responder: RTL
=======================

# rv32_bus_responder

Memory-mapped bus responder that services the CPU's request/response bus (the `o_bus_req_*` / `i_bus_rsp_*` interface driven by the CPU control and LSU). It holds a word-organised RAM and returns one `ack` or `err` per accepted request after a fixed, parameterised latency. It enforces the address window and an optional privilege restriction, and implements the LR/SC reservation set needed by the A extension. It sits on the bus switch as an instruction/data memory target.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `BASE_ADDR`, 0, window base; must be aligned to `MEM_SIZE`.
- `MEM_SIZE`, 8192, window size in bytes; power of two, ≥ 4.
- `WAIT_STATES`, 0, extra response latency in cycles (0..7).
- `PRIV_ONLY`, 0, 1 = reject accesses with `priv=0`.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `i_req_addr` in XLEN: access address.
- `i_req_data` in XLEN: write data.
- `i_req_ben` in 4: byte enables.
- `i_req_we` in 1: write strobe, single cycle.
- `i_req_re` in 1: read strobe, single cycle.
- `i_req_src` in 1: 1 = instruction fetch. Informational only; fetch writes are illegal.
- `i_req_priv` in 1: machine-mode access.
- `i_req_rvso` in 1: reservation-set operation (LR when `re`, SC when `we`).
- `o_rsp_data` out XLEN: read data / SC status.
- `o_rsp_ack` out 1: access done, single-cycle pulse.
- `o_rsp_err` out 1: access error, single-cycle pulse.
- `o_busy` out 1: request outstanding.

## Operation
- **States.** The controller has three states:
  - IDLE → WAIT on an accepted strobe when `WAIT_STATES>0`; otherwise IDLE → RESP.
  - WAIT counts down from `WAIT_STATES-1`. It moves to RESP when the count reaches 0.
  - RESP → IDLE unconditionally.
- **Acceptance.**
  - A strobe is accepted only in IDLE.
  - On acceptance, addr, data, ben, we, priv, rvso and src are registered.
  - A strobe in WAIT or RESP is dropped silently and produces no response.
- **Error conditions.** An error is decided at acceptance if any of the following hold:
  - address outside `[BASE_ADDR, BASE_ADDR+MEM_SIZE)`;
  - `re` and `we` both set;
  - `we` with `src=1`;
  - `PRIV_ONLY=1` and `priv=0`.
- **Error effects.** An error produces `o_rsp_err` in RESP, with `o_rsp_data=0`. There is no memory write and no reservation change.
- **Read.**
  - In RESP, `o_rsp_ack=1` and `o_rsp_data` = the full RAM word at `addr[log2(MEM_SIZE)-1:2]`.
  - `ben` is ignored on reads.
  - `addr[1:0]` is ignored; misalignment is detected by the initiator.
- **Write.** Performed in the RESP cycle, only the bytes with `ben[i]=1`, and `o_rsp_data=0`.
- **LR** (`re & rvso`, no error):
  - the read behaves as a normal read;
  - the reservation becomes valid with word address `addr[XLEN-1:2]`;
  - a new LR replaces any previous reservation.
- **SC** (`we & rvso`, no error):
  - Success (reservation valid and word address matches): the write is performed and `o_rsp_data=0`.
  - Failure: no write and `o_rsp_data=1`.
  - `ack` is returned in both cases. Every SC clears the reservation.
- **Reservation clear.** A normal write (`rvso=0`, no error) to the reserved word clears the reservation.
- **RAM reset.** RAM contents are not reset.

## Timing
- **Latency.** With the strobe in cycle 0, ack/err is asserted in cycle `WAIT_STATES+1` for exactly one cycle.
  - `ack` and `err` are never both asserted.
  - `o_rsp_data` is nonzero only in the ack cycle; it is 0 in every other cycle.
- **`o_busy`.** Asserted from cycle 1 through the response cycle inclusive.
  - A new strobe is accepted at the earliest in the cycle after the response, i.e. cycle `WAIT_STATES+2`.
  - Throughput is one access per `WAIT_STATES+2` cycles.
- **Reset values.** `o_rsp_ack=0`, `o_rsp_err=0`, `o_rsp_data=0`, `o_busy=0`, state=IDLE, wait counter=0, reservation invalid.
- **Reset mid-access.** Reset in WAIT or RESP aborts the access:
  - no response pulse is ever emitted for it;
  - a pending write is not performed;
  - `o_busy=0` from the cycle after reset is asserted.
- **Reset with a strobe.** A strobe in the same cycle as `i_rst` is ignored.
- **Memory timing.** The RAM read is synchronous: the address is registered at acceptance and read into the response register. A write is visible to a read accepted after that write's RESP cycle.

## Structure
- **Package `rv32_bus_pkg`** holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - SC status constants: `SC_OK=0`, `SC_FAIL=1`;
  - the localparam index width `log2(MEM_SIZE)-2`.
- **Sub-module `rv32_bus_resv`** (reservation set): valid flag plus word-address register.
  - Inputs: `set`, `clr_any`, `clr_match`, `addr`.
  - Output: `match`.
- The top level contains the FSM, the wait counter, the RAM array and the response registers.

## Test plan
1. **Write then read** (`WAIT_STATES=2`): write `0xDEADBEEF` to `BASE+0x10`, ben `4'hF`, in cycle 0 → ack in cycle 3 only, `o_busy` in cycles 1–3. Then read `BASE+0x10` → ack 3 cycles later with data `0xDEADBEEF`.
2. **Byte-lane write:** write `0x0000AB00` with ben `4'b0010` to `BASE+0x10` → a later read returns `0xDEADABEF`.
3. **Out-of-window access:** write to `BASE+MEM_SIZE` → err pulse, data 0, no ack. Also `PRIV_ONLY=1` with a `priv=0` read → err. The RAM is unchanged afterwards.
4. **LR/SC success then failure:** LR at `BASE+0x20`, then SC `0x12345678` at `BASE+0x20` → ack with data 0 and the word updated. A second SC with `0x0` → data 1 and the word still `0x12345678`.
5. **Reservation broken by a store:** LR at `BASE+0x20`, normal store to `BASE+0x20`, then SC → data 1 and no write. Repeat with the normal store at `BASE+0x24` → SC succeeds.
6. **Reset and busy strobe:** assert `i_rst` in the WAIT cycle of a write → no ack/err, `o_busy=0` the next cycle, word unchanged, and a subsequent SC fails. A strobe issued while `o_busy=1` → no response for it.

Source files
------------

// File: rtl/rv32_bus_pkg.sv
// Shared definitions for the RV32 bus responder: FSM encoding, SC status
// codes and RAM index sizing.
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic SC_OK   = 1'b0;
    localparam logic SC_FAIL = 1'b1;

    localparam int DEF_MEM_SIZE = 8192;
    localparam int IDX_W        = $clog2(DEF_MEM_SIZE) - 2;

    // Word-index width for a RAM of mem_size bytes (never below one bit).
    function automatic int idx_width(input int mem_size);
        int w;
        w = $clog2(mem_size) - 2;
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/rv32_bus_resv.sv
// LR/SC reservation set: one valid flag plus the reserved word address.
module rv32_bus_resv #(
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic          clr_any,
    input  logic          clr_match,
    input  logic [AW-1:0] addr,
    output logic          match
);

    logic          valid;
    logic [AW-1:0] resv_addr;

    assign match = valid && (resv_addr == addr);

    // A new LR always wins; SC drops the reservation, a plain store only if it hits it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            resv_addr <= '0;
        end else if (set) begin
            valid     <= 1'b1;
            resv_addr <= addr;
        end else if (clr_any || (clr_match && match)) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rv32_bus_responder.sv
// Word-organised RAM target on the CPU request/response bus with fixed
// latency, address-window / privilege checks and an LR/SC reservation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access outstanding, a strobe is accepted here
// ST_WAIT | counting down the configured wait states
// ST_RESP | ack/err pulse cycle; writes and reservation updates commit
module rv32_bus_responder
    import rv32_bus_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  BASE_ADDR   = '0,
    parameter int               MEM_SIZE    = 8192,
    parameter int               WAIT_STATES = 0,
    parameter bit               PRIV_ONLY   = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_data,
    input  logic [3:0]      i_req_ben,
    input  logic            i_req_we,
    input  logic            i_req_re,
    input  logic            i_req_src,
    input  logic            i_req_priv,
    input  logic            i_req_rvso,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_ack,
    output logic            o_rsp_err,
    output logic            o_busy
);

    localparam int              AW        = XLEN - 2;
    localparam int              IW        = idx_width(MEM_SIZE);
    localparam int              DEPTH     = 1 << IW;
    localparam int              WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [XLEN-1:0] WIN_MASK  = ~(XLEN'(MEM_SIZE - 1));

    state_t          state_q, state_d;
    logic [2:0]      cnt_q;
    logic [AW-1:0]   waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      ben_q;
    logic            we_q, re_q, rvso_q, err_q;

    logic            strobe, req_err, accept, to_resp;
    logic [AW-1:0]   cur_waddr;
    logic            cur_re, cur_rvso, cur_err;
    logic [IW-1:0]   cur_idx;
    logic            resv_match, resp_live, do_write;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rsp_data_d, rsp_data_q;
    logic            ack_q, err_rsp_q;

    assign strobe  = i_req_we | i_req_re;
    assign req_err = ((i_req_addr & WIN_MASK) != BASE_ADDR)
                   | (i_req_we & i_req_re)
                   | (i_req_we & i_req_src)
                   | (PRIV_ONLY & ~i_req_priv);

    // Next-state logic; only IDLE accepts, strobes elsewhere are dropped.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    accept  = 1'b1;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: if (cnt_q == 3'd0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign to_resp = (state_d == ST_RESP);

    // With zero wait states the response is prepared straight from the bus
    // inputs, otherwise from the captured request.
    assign cur_waddr = (state_q == ST_IDLE) ? i_req_addr[XLEN-1:2] : waddr_q;
    assign cur_re    = (state_q == ST_IDLE) ? i_req_re   : re_q;
    assign cur_rvso  = (state_q == ST_IDLE) ? i_req_rvso : rvso_q;
    assign cur_err   = (state_q == ST_IDLE) ? req_err    : err_q;
    assign cur_idx   = cur_waddr[IW-1:0];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Request capture at acceptance and the wait-state down-counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= 3'd0;
            waddr_q <= '0;
            wdata_q <= '0;
            ben_q   <= 4'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rvso_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= 3'(WAIT_LOAD);
            waddr_q <= i_req_addr[XLEN-1:2];
            wdata_q <= i_req_data;
            ben_q   <= i_req_ben;
            we_q    <= i_req_we;
            re_q    <= i_req_re;
            rvso_q  <= i_req_rvso;
            err_q   <= req_err;
        end else if ((state_q == ST_WAIT) && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Response payload: read word, SC status, or zero for writes and errors.
    always_comb begin
        rsp_data_d = '0;
        if (!cur_err) begin
            if (cur_re)
                rsp_data_d = mem[cur_idx];
            else if (cur_rvso)
                rsp_data_d = resv_match ? XLEN'(SC_OK) : XLEN'(SC_FAIL);
        end
    end

    // Response registers, loaded on the edge that enters RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q      <= 1'b0;
            err_rsp_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            ack_q      <= to_resp & ~cur_err;
            err_rsp_q  <= to_resp & cur_err;
            rsp_data_q <= to_resp ? rsp_data_d : '0;
        end
    end

    // Reset arriving in the RESP cycle must suppress the pulse already on the outputs.
    assign o_rsp_ack  = ack_q & ~i_rst;
    assign o_rsp_err  = err_rsp_q & ~i_rst;
    assign o_rsp_data = i_rst ? '0 : rsp_data_q;
    assign o_busy     = (state_q != ST_IDLE);

    assign resp_live = (state_q == ST_RESP) && !err_q;
    assign do_write  = resp_live && !i_rst && we_q && (!rvso_q || resv_match);

    // Byte-lane RAM write, committed in the RESP cycle.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (ben_q[i]) mem[waddr_q[IW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    rv32_bus_resv #(.AW(AW)) u_resv (
        .clk       (i_clk),
        .rst       (i_rst),
        .set       (resp_live && re_q && rvso_q),
        .clr_any   (resp_live && we_q && rvso_q),
        .clr_match (resp_live && we_q && !rvso_q),
        .addr      (cur_waddr),
        .match     (resv_match)
    );

endmodule
